perf_counter_bank: RTL and testbench

Memory-mapped performance-counter bank on the CPU data-memory bus. It sits directly downstream of the CPU address-region mux on port 1 (CPU region 4'h2). It consumes the mux's word address, write data and write enable, and returns registered read data one cycle after the address. It holds a free-running cycle counter, NUM_CNT event counters with sticky overflow flags, and a shadow snapshot set for coherent multi-counter reads.

---
 rtl/perf_counter_bank.sv | 162 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Memory-mapped performance-counter bank on the CPU data-memory bus. It contains:
//     - a free-running cycle counter,
//     - NUM_CNT event counters, each with a sticky overflow flag,
//     - a shadow snapshot set, so several counters can be read coherently.
//   Read data is registered and is returned one cycle after the address.
//
// Ports
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   addr  : word address; only addr[5:0] is decoded
//   din   : write data
//   wren  : write strobe
//   dout  : registered read data for the previous cycle's address
//   evt   : event inputs, level-sampled every cycle
//
// Word map (addr[5:0])
//   0x00      CTRL          bit0 EN, bit1 CLR (write-1 pulse), bit2 SNAP (write-1 pulse)
//   0x01      OVF           [NUM_CNT-1:0] event overflow, [63] cycle overflow; write-1-to-clear
//   0x02      CYCLE         live cycle counter
//   0x03      CYCLE_SHADOW  read-only
//   0x08+i    EVT_i         live event counter
//   0x10+i    EVT_SHADOW_i  read-only
module perf_counter_bank #(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned CNT_W   = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        addr,
    input  logic [63:0]        din,
    input  logic               wren,
    output logic [63:0]        dout,
    input  logic [NUM_CNT-1:0] evt
);

    logic [5:0] a;
    assign a = addr[5:0];

    logic unused_addr;
    assign unused_addr = ^addr[63:6];

    // State
    logic               en_q,      en_d;
    logic [CNT_W-1:0]   cyc_q,     cyc_d;
    logic [CNT_W-1:0]   cyc_sh_q,  cyc_sh_d;
    logic               cyc_ovf_q, cyc_ovf_d;
    logic [CNT_W-1:0]   evt_q      [NUM_CNT];
    logic [CNT_W-1:0]   evt_d      [NUM_CNT];
    logic [CNT_W-1:0]   evt_sh_q   [NUM_CNT];
    logic [CNT_W-1:0]   evt_sh_d   [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q,     ovf_d;
    logic [63:0]        dout_q,    dout_d;

    // Write decode
    logic               wr_ctrl, wr_ovf, wr_cyc;
    logic [NUM_CNT-1:0] wr_evt;
    logic               clr, snap;

    always_comb begin
        wr_ctrl = wren && (a == 6'h00);
        wr_ovf  = wren && (a == 6'h01);
        wr_cyc  = wren && (a == 6'h02);
        wr_evt  = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            wr_evt[i] = wren && (a == 6'(8 + i));
        end
        clr  = wr_ctrl & din[1];
        snap = wr_ctrl & din[2];
    end

    // Increment adders. The extra top bit is the carry out, which marks a wrap.
    logic [CNT_W:0] cyc_sum;
    logic [CNT_W:0] evt_sum [NUM_CNT];

    always_comb begin
        cyc_sum = {1'b0, cyc_q} + {{CNT_W{1'b0}}, en_q};
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            evt_sum[i] = {1'b0, evt_q[i]} + {{CNT_W{1'b0}}, en_q & evt[i]};
        end
    end

    // Next-state logic. Priority, from highest to lowest:
    //   CLR > counter write > increment.
    // For an OVF bit:
    //   CLR > set by a wrap > write-1-to-clear.
    // A wrap that coincides with a write to the same counter is discarded.
    always_comb begin
        en_d      = wr_ctrl ? din[0] : en_q;

        cyc_d     = wr_cyc ? din[CNT_W-1:0] : cyc_sum[CNT_W-1:0];
        cyc_ovf_d = (cyc_ovf_q & ~(wr_ovf & din[63])) | (cyc_sum[CNT_W] & ~wr_cyc);
        cyc_sh_d  = snap ? cyc_q : cyc_sh_q;

        ovf_d = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            evt_d[i]    = wr_evt[i] ? din[CNT_W-1:0] : evt_sum[i][CNT_W-1:0];
            ovf_d[i]    = (ovf_q[i] & ~(wr_ovf & din[i])) | (evt_sum[i][CNT_W] & ~wr_evt[i]);
            evt_sh_d[i] = snap ? evt_q[i] : evt_sh_q[i];
        end

        // Shadows above have already sampled the pre-clear values, so CLR can
        // zero the live state unconditionally here.
        if (clr) begin
            cyc_d     = '0;
            cyc_ovf_d = 1'b0;
            ovf_d     = '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                evt_d[i] = '0;
            end
        end
    end

    // Read mux, evaluated on the pre-edge state so read-during-write returns the old value
    always_comb begin
        dout_d = '0;
        unique case (a)
            6'h00: dout_d = 64'(en_q);
            6'h01: begin
                dout_d[NUM_CNT-1:0] = ovf_q;
                dout_d[63]          = cyc_ovf_q;
            end
            6'h02: dout_d = 64'(cyc_q);
            6'h03: dout_d = 64'(cyc_sh_q);
            default: begin
                for (int unsigned i = 0; i < NUM_CNT; i++) begin
                    if (a == 6'(8 + i))  dout_d = 64'(evt_q[i]);
                    if (a == 6'(16 + i)) dout_d = 64'(evt_sh_q[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            cyc_q     <= '0;
            cyc_sh_q  <= '0;
            cyc_ovf_q <= 1'b0;
            ovf_q     <= '0;
            dout_q    <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                evt_q[i]    <= '0;
                evt_sh_q[i] <= '0;
            end
        end else begin
            en_q      <= en_d;
            cyc_q     <= cyc_d;
            cyc_sh_q  <= cyc_sh_d;
            cyc_ovf_q <= cyc_ovf_d;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                evt_q[i]    <= evt_d[i];
                evt_sh_q[i] <= evt_sh_d[i];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank.
//   Directed stimulus with hand-computed expectations.
//   A behavioural register model predicts dout on every cycle.
module tb_perf_counter_bank;

    localparam int unsigned NUM_CNT = 4;
    localparam int unsigned CNT_W   = 48;
    localparam longint unsigned MAXV = (64'd1 << CNT_W) - 64'd1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [63:0]        addr = '0;
    logic [63:0]        din = '0;
    logic               wren = 1'b0;
    logic [63:0]        dout;
    logic [NUM_CNT-1:0] evt = '0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .din  (din),
        .wren (wren),
        .dout (dout),
        .evt  (evt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    longint unsigned m_cyc, m_cyc_sh, m_evt[NUM_CNT], m_sh[NUM_CNT];
    bit              m_en, m_covf;
    bit [NUM_CNT-1:0] m_ovf;
    logic [63:0]     exp_dout = '0;

    longint unsigned o_cyc, nxt;
    longint unsigned o_evt[NUM_CNT];
    bit              ov;
    int              ma;

    function automatic logic [63:0] mread(int a_i);
        logic [63:0] r;
        r = '0;
        if (a_i == 0) begin
            r = 64'(m_en);
        end else if (a_i == 1) begin
            r = 64'(m_ovf);
            r[63] = m_covf;
        end else if (a_i == 2) begin
            r = m_cyc;
        end else if (a_i == 3) begin
            r = m_cyc_sh;
        end else if (a_i >= 8 && a_i < 8 + int'(NUM_CNT)) begin
            r = m_evt[a_i - 8];
        end else if (a_i >= 16 && a_i < 16 + int'(NUM_CNT)) begin
            r = m_sh[a_i - 16];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_cyc_sh = 0; m_en = 0; m_covf = 0; m_ovf = '0;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                m_evt[i] = 0;
                m_sh[i]  = 0;
            end
            exp_dout = '0;
        end else begin
            ma = int'(addr[5:0]);
            exp_dout = mread(ma);
            o_cyc = m_cyc;
            o_evt = m_evt;
            if (wren && ma == 0 && din[2]) begin
                m_cyc_sh = o_cyc;
                m_sh     = o_evt;
            end
            // cycle counter
            nxt = o_cyc + 64'(m_en);
            ov  = nxt > MAXV;
            nxt = nxt & MAXV;
            if (wren && ma == 2) begin
                nxt = din & MAXV;
                ov  = 0;
            end
            m_cyc = nxt;
            if (wren && ma == 1 && din[63]) m_covf = 0;
            if (ov) m_covf = 1;
            // event counters
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                nxt = o_evt[i] + 64'(m_en && evt[i]);
                ov  = nxt > MAXV;
                nxt = nxt & MAXV;
                if (wren && ma == 8 + i) begin
                    nxt = din & MAXV;
                    ov  = 0;
                end
                m_evt[i] = nxt;
                if (wren && ma == 1 && din[i]) m_ovf[i] = 0;
                if (ov) m_ovf[i] = 1;
            end
            if (wren && ma == 0 && din[1]) begin
                m_cyc = 0; m_covf = 0; m_ovf = '0;
                for (int i = 0; i < int'(NUM_CNT); i++) m_evt[i] = 0;
            end
            if (wren && ma == 0) m_en = din[0];
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (dout !== exp_dout) begin
                errors++;
                $display("FAIL model_dout t=%0t got %h exp %h", $time, dout, exp_dout);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        addr = {58'b0, a}; din = d; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0; addr = '0; din = '0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [63:0] v);
        addr = {58'b0, a};
        @(negedge clk);
        v = dout;
        addr = '0;
    endtask

    task automatic rdwr(input logic [5:0] a, input logic [63:0] d, output logic [63:0] v);
        addr = {58'b0, a}; din = d; wren = 1'b1;
        @(negedge clk);
        v = dout;
        wren = 1'b0; addr = '0; din = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [63:0] v;

    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_dout", dout, 64'd0);
        rst = 1'b0;
        rd(6'h00, v); chk("reset_ctrl", v, 64'd0);

        // 1: cycle count from the edge after the EN write
        wr(6'h00, 64'h1);
        idle(10);
        rd(6'h02, v); chk("cycle_10", v, 64'd10);

        // 2: event counting
        evt = 4'b0010; idle(3); evt = '0;
        rd(6'h09, v); chk("evt1_3", v, 64'd3);
        rd(6'h08, v); chk("evt0_0", v, 64'd0);

        // 3: wrap and overflow
        wr(6'h08, MAXV - 64'd1);
        evt = 4'b0001; idle(3); evt = '0;
        rd(6'h08, v); chk("evt0_wrap", v, 64'd1);
        rd(6'h01, v); chk("ovf_set", v, 64'h1);
        wr(6'h01, 64'h1);
        rd(6'h01, v); chk("ovf_w1c", v, 64'h0);
        wr(6'h08, MAXV);
        evt = 4'b0001; wr(6'h01, 64'h1); evt = '0;
        rd(6'h01, v); chk("ovf_set_wins", v, 64'h1);
        rd(6'h08, v); chk("evt0_after_wrap", v, 64'd0);

        // 4: snapshot and clear
        wr(6'h0A, 64'd100);
        evt = 4'b0100;
        wr(6'h00, 64'h5);
        rd(6'h12, v); chk("snap_evt2", v, 64'd100);
        rd(6'h0A, v); chk("evt2_live_a", v, 64'd102);
        rd(6'h0A, v); chk("evt2_live_b", v, 64'd103);
        wr(6'h00, 64'h3);
        rd(6'h0A, v); chk("clr_beats_inc", v, 64'd0);
        evt = '0;
        rd(6'h01, v); chk("clr_ovf", v, 64'd0);
        rd(6'h12, v); chk("shadow_kept", v, 64'd100);
        rd(6'h00, v); chk("ctrl_reads_en", v, 64'd1);

        // 5: write beats increment, read-during-write
        evt = 4'b0010; wr(6'h09, 64'd7); evt = '0;
        rd(6'h09, v); chk("wr_beats_inc", v, 64'd7);
        rdwr(6'h09, 64'd55, v); chk("rdw_old", v, 64'd7);
        rd(6'h09, v); chk("rdw_new", v, 64'd55);

        // 6: asynchronous reset mid-count, unmapped and read-only words
        evt = 4'b1111;
        #2 rst = 1'b1;
        #1 chk("async_rst_dout", dout, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; evt = '0;
        rd(6'h02, v); chk("rst_cycle", v, 64'd0);
        rd(6'h0B, v); chk("rst_evt3", v, 64'd0);
        rd(6'h12, v); chk("rst_shadow", v, 64'd0);
        rd(6'h20, v); chk("unmapped_20", v, 64'd0);
        wr(6'h0C, 64'd9);
        rd(6'h0C, v); chk("unmapped_0C", v, 64'd0);
        wr(6'h03, 64'd123);
        rd(6'h03, v); chk("ro_cycle_shadow", v, 64'd0);

        idle(2);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
